// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store data memory.
//   size_e            access size encoding (byte/half/word/dword)
//   state_e           request FSM states
//   MMIO_CYCLE_OFFSET left shift applied to an all-ones address to form the
//                     cycle-counter address (used when LSU_MMIO_CYCLE_EN is set)
//   misaligned()      natural-alignment check for an access size
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int MMIO_CYCLE_OFFSET = 8;

  // An access is misaligned when any address bit below its size is set.
  function automatic logic misaligned(input size_e sz, input logic [2:0] lo);
    case (sz)
      SZ_HALF:  return lo[0];
      SZ_WORD:  return |lo[1:0];
      SZ_DWORD: return |lo;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane handling for one memory word.
//   i_size     access size
//   i_unsigned zero-extend loads when set, otherwise sign-extend
//   i_offset   byte lane offset within the word
//   i_rword    word read from storage
//   i_wdata    right-aligned store data
//   o_rdata    extracted and extended load data
//   o_wdata    store data shifted into the addressed lanes
//   o_be       byte enables for the addressed lanes
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  size_e                             i_size,
  input  logic                              i_unsigned,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]   i_offset,
  input  logic [DATA_WIDTH-1:0]             i_rword,
  input  logic [DATA_WIDTH-1:0]             i_wdata,
  output logic [DATA_WIDTH-1:0]             o_rdata,
  output logic [DATA_WIDTH-1:0]             o_wdata,
  output logic [DATA_WIDTH/8-1:0]           o_be
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DATA_WIDTH);

  logic [OFF_W+2:0]       w_shift;
  logic [DATA_WIDTH-1:0]  w_raw;
  logic [3:0]             w_nbytes;
  logic [IDX_W-1:0]       w_msb;
  logic                   w_sign;
  logic [NB-1:0]          w_be_base;

  assign w_shift = {i_offset, 3'b000};
  assign w_raw   = i_rword >> w_shift;

  // Access width is clamped to the bus so an illegal dword on a 32-bit bus
  // never indexes past the word; the top reports that case as an error.
  always_comb begin
    w_nbytes  = 4'd1 << i_size;
    if (int'(w_nbytes) > NB) w_nbytes = 4'(NB);
    w_msb     = IDX_W'(8 * int'(w_nbytes) - 1);
    w_sign    = ~i_unsigned & w_raw[w_msb];
    o_rdata   = '0;
    w_be_base = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      o_rdata[i] = (i < 8 * int'(w_nbytes)) ? w_raw[i] : w_sign;
    end
    for (int b = 0; b < NB; b++) begin
      w_be_base[b] = (b < int'(w_nbytes));
    end
  end

  assign o_be    = w_be_base << i_offset;
  assign o_wdata = i_wdata << w_shift;

endmodule

// File: rtl/lsu_data_mem.sv
// lsu_data_mem: handshaked load/store data memory with wait states.
//   i_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//   i_req_valid/o_req_ready request handshake (ready only in IDLE)
//   i_req_we                1 = store, 0 = load
//   i_req_size              0 byte, 1 half, 2 word, 3 dword (64-bit bus only)
//   i_req_unsigned          zero-extend loads
//   i_req_addr              byte address
//   i_req_wdata             right-aligned store data
//   o_rsp_valid             one-cycle response pulse, WAIT_STATES+1 after accept
//   o_rsp_rdata             extended load data, 0 for stores and errors
//   o_rsp_err               misaligned, illegal size or out-of-range access
// Optional macro LSU_MMIO_CYCLE_EN maps a read-only free-running cycle counter
// at address {all ones} << MMIO_CYCLE_OFFSET (word loads only).
module lsu_data_mem
  import lsu_pkg::*;
#(
  parameter int    DATA_WIDTH  = 32,
  parameter int    DEPTH_LOG2  = 10,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [DATA_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err
);

  localparam int         NB        = DATA_WIDTH / 8;
  localparam int         OFF_W     = $clog2(NB);
  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e                r_state, w_next_state;
  logic [3:0]            r_wait_cnt;
  logic                  r_we, r_unsigned;
  size_e                 r_size;
  logic [DATA_WIDTH-1:0] r_addr, r_wdata;
  logic                  r_rsp_valid, r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_ready, w_accept, w_commit;
  logic                  w_oor, w_size_bad, w_err;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [DATA_WIDTH-1:0] w_rword, w_load_data, w_store_data, w_rsp_data;
  logic [NB-1:0]         w_be;

  assign w_accept = i_req_valid && w_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (i_req_valid) w_next_state = (WAIT_STATES > 0) ? WAIT : RESP;
      end
      WAIT:    if (r_wait_cnt == 4'd0) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign o_req_ready = w_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= SZ_BYTE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wait_cnt <= 4'd0;
    end else if (w_accept) begin
      r_we       <= i_req_we;
      r_unsigned <= i_req_unsigned;
      r_size     <= size_e'(i_req_size);
      r_addr     <= i_req_addr;
      r_wdata    <= i_req_wdata;
      r_wait_cnt <= WAIT_LOAD;
    end else if (r_state == WAIT && r_wait_cnt != 4'd0) begin
      r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end

  assign w_idx      = r_addr[OFF_W+DEPTH_LOG2-1:OFF_W];
  assign w_oor      = |r_addr[DATA_WIDTH-1:OFF_W+DEPTH_LOG2];
  assign w_size_bad = (DATA_WIDTH == 32) && (r_size == SZ_DWORD);
  assign w_rword    = r_mem[w_idx];

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_offset   (r_addr[OFF_W-1:0]),
    .i_rword    (w_rword),
    .i_wdata    (r_wdata),
    .o_rdata    (w_load_data),
    .o_wdata    (w_store_data),
    .o_be       (w_be)
  );

`ifdef LSU_MMIO_CYCLE_EN
  localparam logic [DATA_WIDTH-1:0] MMIO_ADDR = {DATA_WIDTH{1'b1}} << MMIO_CYCLE_OFFSET;

  logic [DATA_WIDTH-1:0] r_cycle;
  logic                  w_is_mmio;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cycle <= '0;
    else          r_cycle <= r_cycle + 1'b1;
  end

  // The counter address skips the normal checks; only word loads are legal.
  assign w_is_mmio  = (r_addr == MMIO_ADDR);
  assign w_err      = w_is_mmio ? (r_we || r_size != SZ_WORD)
                                : (misaligned(r_size, r_addr[2:0]) || w_size_bad || w_oor);
  assign w_rsp_data = (r_we || w_err) ? '0 : (w_is_mmio ? r_cycle : w_load_data);
  assign w_commit   = (r_state == RESP) && r_we && !w_err && !w_is_mmio;
`else
  assign w_err      = misaligned(r_size, r_addr[2:0]) || w_size_bad || w_oor;
  assign w_rsp_data = (r_we || w_err) ? '0 : w_load_data;
  assign w_commit   = (r_state == RESP) && r_we && !w_err;
`endif

  // The response is registered on the RESP edge, so it appears the cycle
  // after RESP while the FSM is already back in IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= (r_state == RESP);
      r_rsp_err   <= (r_state == RESP) && w_err;
      r_rsp_rdata <= (r_state == RESP) ? w_rsp_data : '0;
    end
  end

  // Storage has no reset; only the addressed lanes are written.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < NB; b++) begin
      if (w_commit && w_be[b]) r_mem[w_idx][8*b +: 8] <= w_store_data[8*b +: 8];
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_lsu_data_mem.sv
// tb_lsu_data_mem: directed checks of a 32-bit (1 wait state) and a 64-bit
// (no wait states) instance of lsu_data_mem.
module tb_lsu_data_mem;
  import lsu_pkg::*;

  localparam logic [1:0] SB = 2'd0, SH = 2'd1, SW = 2'd2, SD = 2'd3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tbCycle = 0;
  always @(posedge clk) tbCycle++;

  logic        v32, rdy32, we32, uns32, rv32, re32;
  logic [1:0]  size32;
  logic [31:0] addr32, wd32, rd32;
  logic        v64, rdy64, we64, uns64, rv64, re64;
  logic [1:0]  size64;
  logic [63:0] addr64, wd64, rd64;

  int errors = 0;
  int checks = 0;

  lsu_data_mem #(.DATA_WIDTH(32), .DEPTH_LOG2(10), .WAIT_STATES(1)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v32), .o_req_ready(rdy32),
    .i_req_we(we32), .i_req_size(size32), .i_req_unsigned(uns32),
    .i_req_addr(addr32), .i_req_wdata(wd32), .o_rsp_valid(rv32),
    .o_rsp_rdata(rd32), .o_rsp_err(re32)
  );

  lsu_data_mem #(.DATA_WIDTH(64), .DEPTH_LOG2(10), .WAIT_STATES(0)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v64), .o_req_ready(rdy64),
    .i_req_we(we64), .i_req_size(size64), .i_req_unsigned(uns64),
    .i_req_addr(addr64), .i_req_wdata(wd64), .o_rsp_valid(rv64),
    .o_rsp_rdata(rd64), .o_rsp_err(re64)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request to the chosen instance and wait for its response.
  // lat counts clock edges from accept to the visible rsp_valid pulse.
  task automatic applyStimulus(input bit is64, input logic we, input logic [1:0] size,
                               input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                               output logic [63:0] rdata, output logic err,
                               output int lat, output int stamp);
    int n;
    bit done;
    @(negedge clk);
    if (is64) begin
      we64 = we; size64 = size; uns64 = uns; addr64 = addr; wd64 = wdata; v64 = 1'b1;
    end else begin
      we32 = we; size32 = size; uns32 = uns; addr32 = addr[31:0]; wd32 = wdata[31:0]; v32 = 1'b1;
    end
    n = 0;
    while (!(is64 ? rdy64 : rdy32) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) checkOutput("ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    v32 = 1'b0;
    v64 = 1'b0;
    rdata = '0; err = 1'b0; lat = 0; stamp = 0; done = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (is64 ? rv64 : rv32) begin
        done  = 1'b1;
        rdata = is64 ? rd64 : {32'd0, rd32};
        err   = is64 ? re64 : re32;
        stamp = tbCycle;
      end
    end
    if (!done) checkOutput("rsp_timeout", 64'd0, 64'd1);
  endtask

  logic [63:0] rd, c0;
  logic        er;
  int          lat, st, s0, pulses;

  initial begin
    rst_n = 1'b0;
    v32 = 0; we32 = 0; size32 = 0; uns32 = 0; addr32 = 0; wd32 = 0;
    v64 = 0; we64 = 0; size64 = 0; uns64 = 0; addr64 = 0; wd64 = 0;
    #2;
    checkOutput("rst_ready32", 64'(rdy32), 64'd1);
    checkOutput("rst_valid32", 64'(rv32), 64'd0);
    checkOutput("rst_rdata32", 64'(rd32), 64'd0);
    checkOutput("rst_err32", 64'(re32), 64'd0);
    checkOutput("rst_ready64", 64'(rdy64), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 32-bit word store/load
    applyStimulus(0, 1, SW, 0, 'h10, 'hDEADBEEF, rd, er, lat, st);
    checkOutput("st_w_err", 64'(er), 0); checkOutput("st_w_rdata", rd, 0); checkOutput("st_w_lat", 64'(lat), 2);
    applyStimulus(0, 0, SW, 0, 'h10, 0, rd, er, lat, st);
    checkOutput("ld_w", rd, 'hDEADBEEF); checkOutput("ld_w_err", 64'(er), 0); checkOutput("ld_w_lat", 64'(lat), 2);

    // byte store and extension
    applyStimulus(0, 1, SB, 0, 'h13, 'h80, rd, er, lat, st);
    applyStimulus(0, 0, SW, 0, 'h10, 0, rd, er, lat, st);
    checkOutput("ld_w_after_sb", rd, 'h80ADBEEF);
    applyStimulus(0, 0, SB, 0, 'h13, 0, rd, er, lat, st);
    checkOutput("ld_b_signed", rd, 'hFFFFFF80);
    applyStimulus(0, 0, SB, 1, 'h13, 0, rd, er, lat, st);
    checkOutput("ld_b_unsigned", rd, 'h00000080);
    applyStimulus(0, 0, SH, 0, 'h12, 0, rd, er, lat, st);
    checkOutput("ld_h_signed", rd, 'hFFFF80AD);
    applyStimulus(0, 0, SH, 1, 'h12, 0, rd, er, lat, st);
    checkOutput("ld_h_unsigned", rd, 'h000080AD);
    applyStimulus(0, 1, SH, 0, 'h10, 'hFFFF1234, rd, er, lat, st);
    applyStimulus(0, 0, SW, 0, 'h10, 0, rd, er, lat, st);
    checkOutput("ld_w_after_sh", rd, 'h80AD1234);

    // errors
    applyStimulus(0, 0, SH, 0, 'h11, 0, rd, er, lat, st);
    checkOutput("mis_h_err", 64'(er), 1); checkOutput("mis_h_rdata", rd, 0);
    applyStimulus(0, 1, SW, 0, 'h12, 'h11111111, rd, er, lat, st);
    checkOutput("mis_sw_err", 64'(er), 1);
    applyStimulus(0, 0, SW, 0, 'h10, 0, rd, er, lat, st);
    checkOutput("mis_sw_nowrite", rd, 'h80AD1234);
    applyStimulus(0, 0, SW, 0, 'h1000, 0, rd, er, lat, st);
    checkOutput("oor_err", 64'(er), 1); checkOutput("oor_rdata", rd, 0);
    applyStimulus(0, 0, SD, 0, 'h8, 0, rd, er, lat, st);
    checkOutput("dword32_err", 64'(er), 1);

    // 64-bit, no wait states
    applyStimulus(1, 1, SD, 0, 'h8, 'h0123456789ABCDEF, rd, er, lat, st);
    checkOutput("st_d_lat", 64'(lat), 1); checkOutput("st_d_err", 64'(er), 0);
    applyStimulus(1, 0, SW, 0, 'hC, 0, rd, er, lat, st);
    checkOutput("ld_w64_hi", rd, 'h0000000001234567); checkOutput("ld_w64_lat", 64'(lat), 1);
    applyStimulus(1, 0, SW, 0, 'h8, 0, rd, er, lat, st);
    checkOutput("ld_w64_lo_signed", rd, 'hFFFFFFFF89ABCDEF);
    applyStimulus(1, 0, SD, 0, 'h8, 0, rd, er, lat, st);
    checkOutput("ld_d64", rd, 'h0123456789ABCDEF);
    applyStimulus(1, 0, SB, 0, 'hF, 0, rd, er, lat, st);
    checkOutput("ld_b64", rd, 'h1);
    applyStimulus(1, 0, SD, 0, 'hC, 0, rd, er, lat, st);
    checkOutput("mis_d64_err", 64'(er), 1);
    applyStimulus(1, 0, SD, 0, 'h2000, 0, rd, er, lat, st);
    checkOutput("oor64_err", 64'(er), 1);

    // reset during the wait state of a store aborts it
    applyStimulus(0, 1, SW, 0, 'h20, 'h11223344, rd, er, lat, st);
    @(negedge clk);
    we32 = 1; size32 = SW; uns32 = 0; addr32 = 'h20; wd32 = 'h55667788; v32 = 1;
    @(posedge clk);
    #1;
    v32 = 0;
    checkOutput("wait_ready", 64'(rdy32), 0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_ready", 64'(rdy32), 1);
    checkOutput("abort_valid", 64'(rv32), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (rv32) pulses++;
    end
    checkOutput("abort_norsp", 64'(pulses), 0);
    applyStimulus(0, 0, SW, 0, 'h20, 0, rd, er, lat, st);
    checkOutput("abort_nowrite", rd, 'h11223344);

`ifdef LSU_MMIO_CYCLE_EN
    applyStimulus(0, 0, SW, 1, 'hFFFFFF00, 0, rd, er, lat, st);
    checkOutput("mmio_err0", 64'(er), 0);
    c0 = rd;
    s0 = st;
    repeat (5) @(posedge clk);
    applyStimulus(0, 0, SW, 1, 'hFFFFFF00, 0, rd, er, lat, st);
    checkOutput("mmio_err1", 64'(er), 0);
    checkOutput("mmio_delta", 64'(rd[31:0] - c0[31:0]), 64'(32'(st - s0)));
    applyStimulus(0, 1, SW, 0, 'hFFFFFF00, 'h5, rd, er, lat, st);
    checkOutput("mmio_store_err", 64'(er), 1);
    applyStimulus(0, 0, SB, 1, 'hFFFFFF00, 0, rd, er, lat, st);
    checkOutput("mmio_byte_err", 64'(er), 1);
`else
    applyStimulus(0, 0, SW, 1, 'hFFFFFF00, 0, rd, er, lat, st);
    checkOutput("mmio_off_oor_err", 64'(er), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
